// File: rtl/imem_ctrl_if.sv
// Instruction memory controller bus: loader stream, core fetch port and
// the single-port instruction RAM, bundled for the controller boundary.
interface imem_ctrl_if #(
  parameter int AW = 10
);
  // loader stream
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  // core side
  logic          reload;
  logic          fetch_req;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          fetch_err;
  logic          core_rst_n;
  logic          load_ovf;
  // memory port
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // controller side
  modport slave (
    input  ld_valid, ld_data, ld_last, reload, fetch_req, pc, mem_rdata,
    output ld_ready, instr, instr_valid, fetch_err, core_rst_n, load_ovf,
           mem_addr, mem_we, mem_wdata
  );

  // environment side (loader + core + memory)
  modport master (
    output ld_valid, ld_data, ld_last, reload, fetch_req, pc, mem_rdata,
    input  ld_ready, instr, instr_valid, fetch_err, core_rst_n, load_ovf,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_ctrl.sv
// Instruction memory controller: streams a program image into the RAM while
// the core is held in reset, then releases the core and serves its fetches
// with one-cycle latency. The RAM port belongs to the loader in LOAD, to the
// core in RUN.
module imem_ctrl #(
  parameter int          DEPTH = 1024,
  parameter int          AW    = 10,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       rst,
  imem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state, nxt;
  logic [AW-1:0] wr_cnt, wr_cnt_nxt;
  logic          ovf, ovf_nxt;
  logic          ld_rdy, accept, at_end;
  logic          fetch_go, fault;
  logic          vld_q, err_q;

  // Loader is only accepted outside RUN, and never while reset is held so
  // that no write can leak out during reset.
  assign ld_rdy   = rst && (state != RUN);
  assign accept   = bus.ld_valid && ld_rdy;
  assign at_end   = (wr_cnt == AW'(DEPTH - 1));

  // A fetch is launched only in RUN; a same-cycle reload kills it.
  assign fetch_go = (state == RUN) && bus.fetch_req && !bus.reload;
  assign fault    = (bus.pc[1:0] != 2'b00) || (|bus.pc[31:AW+2]);

  // State, write pointer and overflow flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= nxt;
      wr_cnt <= wr_cnt_nxt;
      ovf    <= ovf_nxt;
    end
  end

  // Next-state: load sequencing, overflow detection, reload handling
  always_comb begin
    nxt        = state;
    wr_cnt_nxt = wr_cnt;
    ovf_nxt    = ovf;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          // a fresh load clears any overflow left from the previous image
          if (state == IDLE) ovf_nxt = 1'b0;
          // the pointer saturates at the last word rather than wrapping
          if (!at_end) wr_cnt_nxt = wr_cnt + 1'b1;
          if (bus.ld_last) begin
            nxt = RUN;
          end else if (at_end) begin
            nxt     = RUN;
            ovf_nxt = 1'b1;
          end else begin
            nxt = LOAD;
          end
        end
      end
      RUN: begin
        if (bus.reload) begin
          nxt        = IDLE;
          wr_cnt_nxt = '0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Fetch response pipeline: valid and fault captured at request time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      vld_q <= fetch_go;
      err_q <= fetch_go && fault;
    end
  end

  assign bus.ld_ready    = ld_rdy;
  assign bus.mem_we      = accept;
  assign bus.mem_wdata   = bus.ld_data;
  assign bus.mem_addr    = (state == RUN) ? bus.pc[AW+1:2] : wr_cnt;
  assign bus.core_rst_n  = (state == RUN);
  assign bus.load_ovf    = ovf;
  assign bus.instr_valid = vld_q;
  assign bus.fetch_err   = vld_q && err_q;
  assign bus.instr       = !vld_q ? '0 : (err_q ? NOP : bus.mem_rdata);

endmodule
